// File: rtl/ycr1_icache_sched.sv
// ycr1_icache_sched: shares the single icache request port between the core imem
// and dmem requesters. Request phases are arbitrated (round-robin, or fixed dmem
// priority when YCR1_ICACHE_SCHED_DPRIO_EN is defined). The owner of every accepted
// request is pushed into an in-order ID FIFO, and each response beat is routed back
// to the FIFO head owner with no added latency.
module ycr1_icache_sched #(
  parameter int unsigned OUTST = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // imem requester
  input  logic                       imem_req,
  input  logic                       imem_cmd,
  input  logic [1:0]                 imem_width,
  input  logic [AW-1:0]              imem_addr,
  output logic                       imem_req_ack,
  output logic [DW-1:0]              imem_rdata,
  output logic [1:0]                 imem_resp,
  // dmem requester
  input  logic                       dmem_req,
  input  logic                       dmem_cmd,
  input  logic [1:0]                 dmem_width,
  input  logic [AW-1:0]              dmem_addr,
  output logic                       dmem_req_ack,
  output logic [DW-1:0]              dmem_rdata,
  output logic [1:0]                 dmem_resp,
  // shared icache port
  output logic                       icache_req,
  output logic                       icache_cmd,
  output logic [1:0]                 icache_width,
  output logic [AW-1:0]              icache_addr,
  input  logic                       icache_req_ack,
  input  logic [DW-1:0]              icache_rdata,
  input  logic [1:0]                 icache_resp,
  output logic [$clog2(OUTST+1)-1:0] outst_cnt
);

  localparam int unsigned CW = $clog2(OUTST + 1);
  localparam int unsigned PW = (OUTST > 1) ? $clog2(OUTST) : 1;

  localparam logic OwnImem = 1'b0;
  localparam logic OwnDmem = 1'b1;

  // Owner ID FIFO (one bit per entry) and its occupancy
  logic [OUTST-1:0] owner_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Grant lock held while the icache stalls an issued request
  logic lock_q, lock_d;
  logic lock_own_q, lock_own_d;

`ifndef YCR1_ICACHE_SCHED_DPRIO_EN
  // Round-robin preference: requester favoured when both are active
  logic rr_q, rr_d;
`endif

  logic sel;
  logic sel_req;
  logic lock_live;
  logic full;
  logic empty;
  logic accept;
  logic resp_beat;
  logic head_own;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // A lock only counts while its owner still requests; a dropped req releases it
  assign lock_live = lock_q && ((lock_own_q == OwnDmem) ? dmem_req : imem_req);

  // Select the requester whose attributes drive the icache this cycle
  always_comb begin
    sel = OwnImem;
    if (lock_live) begin
      sel = lock_own_q;
    end else if (imem_req && !dmem_req) begin
      sel = OwnImem;
    end else if (dmem_req && !imem_req) begin
      sel = OwnDmem;
    end else begin
`ifdef YCR1_ICACHE_SCHED_DPRIO_EN
      sel = dmem_req ? OwnDmem : OwnImem;
`else
      sel = rr_q;
`endif
    end
  end

  assign sel_req   = (sel == OwnDmem) ? dmem_req : imem_req;
  assign full      = (cnt_q == CW'(OUTST));
  assign empty     = (cnt_q == '0);
  // Full check uses the pre-pop count: no push while full even if a pop occurs
  assign accept    = icache_req && icache_req_ack;
  assign resp_beat = (icache_resp != 2'b00) && !empty;
  assign head_own  = owner_q[rd_ptr_q];

  // Muxed request towards the icache; forced quiet while reset is asserted
  always_comb begin
    icache_req   = 1'b0;
    icache_cmd   = 1'b0;
    icache_width = '0;
    icache_addr  = '0;
    if (rst_n) begin
      icache_req   = sel_req && !full;
      icache_cmd   = (sel == OwnDmem) ? dmem_cmd   : imem_cmd;
      icache_width = (sel == OwnDmem) ? dmem_width : imem_width;
      icache_addr  = (sel == OwnDmem) ? dmem_addr  : imem_addr;
    end
  end

  // Request acks and response routing back to the requesters
  always_comb begin
    imem_req_ack = accept && (sel == OwnImem);
    dmem_req_ack = accept && (sel == OwnDmem);
    imem_resp    = 2'b00;
    imem_rdata   = '0;
    dmem_resp    = 2'b00;
    dmem_rdata   = '0;
    if (resp_beat) begin
      if (head_own == OwnDmem) begin
        dmem_resp  = icache_resp;
        dmem_rdata = icache_rdata;
      end else begin
        imem_resp  = icache_resp;
        imem_rdata = icache_rdata;
      end
    end
  end

  // Next-state for lock and occupancy
  always_comb begin
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    if (accept) begin
      lock_d = 1'b0;
    end else if (icache_req) begin
      lock_d     = 1'b1;
      lock_own_d = sel;
    end else if (lock_q && !lock_live) begin
      lock_d = 1'b0;
    end
    cnt_d = cnt_q + CW'(accept) - CW'(resp_beat);
  end

`ifndef YCR1_ICACHE_SCHED_DPRIO_EN
  // After an accept, prefer the requester that was not served
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = ~sel;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= OwnImem;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Lock and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_own_q <= OwnImem;
      cnt_q      <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      cnt_q      <= cnt_d;
    end
  end

  // Owner FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (accept) begin
        owner_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (resp_beat) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  assign outst_cnt = cnt_q;

endmodule

// File: tb/tb_ycr1_icache_sched.sv
// Directed self-checking bench for ycr1_icache_sched (OUTST=2, AW=DW=32).
module tb_ycr1_icache_sched;

  localparam int unsigned OUTST = 2;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(OUTST + 1);

  logic          clk;
  logic          rst_n;
  logic          imem_req, imem_cmd;
  logic [1:0]    imem_width;
  logic [AW-1:0] imem_addr;
  logic          imem_req_ack;
  logic [DW-1:0] imem_rdata;
  logic [1:0]    imem_resp;
  logic          dmem_req, dmem_cmd;
  logic [1:0]    dmem_width;
  logic [AW-1:0] dmem_addr;
  logic          dmem_req_ack;
  logic [DW-1:0] dmem_rdata;
  logic [1:0]    dmem_resp;
  logic          icache_req, icache_cmd;
  logic [1:0]    icache_width;
  logic [AW-1:0] icache_addr;
  logic          icache_req_ack;
  logic [DW-1:0] icache_rdata;
  logic [1:0]    icache_resp;
  logic [CW-1:0] outst_cnt;

  int checks   = 0;
  int failures = 0;

  ycr1_icache_sched #(.OUTST(OUTST), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_cmd       (imem_cmd),
    .imem_width     (imem_width),
    .imem_addr      (imem_addr),
    .imem_req_ack   (imem_req_ack),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .dmem_req       (dmem_req),
    .dmem_cmd       (dmem_cmd),
    .dmem_width     (dmem_width),
    .dmem_addr      (dmem_addr),
    .dmem_req_ack   (dmem_req_ack),
    .dmem_rdata     (dmem_rdata),
    .dmem_resp      (dmem_resp),
    .icache_req     (icache_req),
    .icache_cmd     (icache_cmd),
    .icache_width   (icache_width),
    .icache_addr    (icache_addr),
    .icache_req_ack (icache_req_ack),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .outst_cnt      (outst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling
  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req = 1'b0; imem_cmd = 1'b0; imem_width = 2'd2; imem_addr = '0;
    dmem_req = 1'b0; dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = '0;
    icache_req_ack = 1'b0; icache_rdata = '0; icache_resp = 2'b00;

    // Reset state
    settle();
    check("rst_cnt", 64'(outst_cnt), 64'd0);
    check("rst_icache_req", 64'(icache_req), 64'd0);
    check("rst_icache_addr", 64'(icache_addr), 64'd0);
    check("rst_imem_resp", 64'(imem_resp), 64'd0);
    check("rst_dmem_resp", 64'(dmem_resp), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

`ifndef YCR1_ICACHE_SCHED_DPRIO_EN
    // Round-robin: both request continuously, 1-cycle responses
    imem_req = 1'b1; imem_addr = 32'h1000;
    dmem_req = 1'b1; dmem_addr = 32'h2000;
    icache_req_ack = 1'b1;
    settle();
    check("rr0_addr", 64'(icache_addr), 64'h1000);
    check("rr0_iack", 64'(imem_req_ack), 64'd1);
    check("rr0_dack", 64'(dmem_req_ack), 64'd0);
    tick();
    icache_resp = 2'b01; icache_rdata = 32'hA0;
    settle();
    check("rr1_addr", 64'(icache_addr), 64'h2000);
    check("rr1_dack", 64'(dmem_req_ack), 64'd1);
    check("rr1_iresp", 64'(imem_resp), 64'd1);
    check("rr1_irdata", 64'(imem_rdata), 64'hA0);
    check("rr1_dresp", 64'(dmem_resp), 64'd0);
    check("rr1_cnt", 64'(outst_cnt), 64'd1);
    tick();
    icache_rdata = 32'hA1;
    settle();
    check("rr2_iack", 64'(imem_req_ack), 64'd1);
    check("rr2_dresp", 64'(dmem_resp), 64'd1);
    check("rr2_drdata", 64'(dmem_rdata), 64'hA1);
    check("rr2_iresp", 64'(imem_resp), 64'd0);
    tick();
    icache_rdata = 32'hA2;
    settle();
    check("rr3_dack", 64'(dmem_req_ack), 64'd1);
    check("rr3_irdata", 64'(imem_rdata), 64'hA2);
    tick();
    imem_req = 1'b0; dmem_req = 1'b0;
    icache_rdata = 32'hA3;
    settle();
    check("rr4_cnt_before", 64'(outst_cnt), 64'd1);
    check("rr4_drdata", 64'(dmem_rdata), 64'hA3);
    check("rr4_iresp", 64'(imem_resp), 64'd0);
    tick();
    icache_resp = 2'b00; icache_rdata = '0;
    settle();
    check("rr_end_cnt", 64'(outst_cnt), 64'd0);
`else
    // Fixed priority: dmem wins every contended cycle
    imem_req = 1'b1; imem_addr = 32'h1000;
    dmem_req = 1'b1; dmem_addr = 32'h2000;
    icache_req_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("dp_dack", 64'(dmem_req_ack), 64'd1);
      check("dp_iack", 64'(imem_req_ack), 64'd0);
      check("dp_addr", 64'(icache_addr), 64'h2000);
      tick();
      icache_resp = 2'b01; icache_rdata = 32'hE0;
    end
    imem_req = 1'b0; dmem_req = 1'b0;
    settle();
    check("dp_dresp", 64'(dmem_resp), 64'd1);
    tick();
    icache_resp = 2'b00;
    settle();
    check("dp_end_cnt", 64'(outst_cnt), 64'd0);
`endif

    // Outstanding limit with dmem-only traffic, responses withheld
    dmem_req = 1'b1; dmem_addr = 32'h3000; icache_req_ack = 1'b1;
    settle();
    check("full0_dack", 64'(dmem_req_ack), 64'd1);
    tick();
    settle();
    check("full1_cnt", 64'(outst_cnt), 64'd1);
    check("full1_dack", 64'(dmem_req_ack), 64'd1);
    tick();
    settle();
    check("full2_cnt", 64'(outst_cnt), 64'd2);
    check("full2_req", 64'(icache_req), 64'd0);
    check("full2_dack", 64'(dmem_req_ack), 64'd0);
    check("full2_addr", 64'(icache_addr), 64'h3000);
    tick();
    icache_resp = 2'b01; icache_rdata = 32'hB0;
    settle();
    check("full3_req_prepop", 64'(icache_req), 64'd0);
    check("full3_dresp", 64'(dmem_resp), 64'd1);
    check("full3_drdata", 64'(dmem_rdata), 64'hB0);
    tick();
    icache_resp = 2'b00;
    settle();
    check("full4_cnt", 64'(outst_cnt), 64'd1);
    check("full4_dack", 64'(dmem_req_ack), 64'd1);
    tick();
    dmem_req = 1'b0; icache_resp = 2'b01;
    settle();
    check("full5_cnt", 64'(outst_cnt), 64'd2);
    tick();
    tick();
    icache_resp = 2'b00;
    settle();
    check("full_end_cnt", 64'(outst_cnt), 64'd0);

    // Icache stall locks the dmem write grant while imem raises req
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_addr = 32'h2000; icache_req_ack = 1'b0;
    settle();
    check("lk0_req", 64'(icache_req), 64'd1);
    check("lk0_cmd", 64'(icache_cmd), 64'd1);
    check("lk0_dack", 64'(dmem_req_ack), 64'd0);
    tick();
    imem_req = 1'b1; imem_addr = 32'h1000;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("lk_addr", 64'(icache_addr), 64'h2000);
      check("lk_iack", 64'(imem_req_ack), 64'd0);
      check("lk_dack", 64'(dmem_req_ack), 64'd0);
      tick();
    end
    icache_req_ack = 1'b1;
    settle();
    check("lk3_dack", 64'(dmem_req_ack), 64'd1);
    check("lk3_iack", 64'(imem_req_ack), 64'd0);
    tick();
    dmem_req = 1'b0; dmem_cmd = 1'b0;
    settle();
    check("lk4_iack", 64'(imem_req_ack), 64'd1);
    check("lk4_addr", 64'(icache_addr), 64'h1000);
    tick();
    imem_req = 1'b0;
    icache_resp = 2'b01; icache_rdata = 32'hD0;
    settle();
    check("lk5_dresp", 64'(dmem_resp), 64'd1);
    check("lk5_iresp", 64'(imem_resp), 64'd0);
    tick();
    icache_rdata = 32'hD1;
    settle();
    check("lk6_iresp", 64'(imem_resp), 64'd1);
    check("lk6_irdata", 64'(imem_rdata), 64'hD1);
    tick();
    icache_resp = 2'b00; icache_rdata = '0;

    // Spurious response with FIFO empty is ignored
    icache_resp = 2'b01; icache_rdata = 32'hFF;
    settle();
    check("sp_iresp", 64'(imem_resp), 64'd0);
    check("sp_dresp", 64'(dmem_resp), 64'd0);
    check("sp_irdata", 64'(imem_rdata), 64'd0);
    tick();
    icache_resp = 2'b00; icache_rdata = '0;
    settle();
    check("sp_cnt", 64'(outst_cnt), 64'd0);

    // Reset in the middle of traffic
    imem_req = 1'b1; imem_addr = 32'h1000; icache_req_ack = 1'b1;
    tick();
    tick();
    settle();
    check("mr_cnt_before", 64'(outst_cnt), 64'd2);
    icache_resp = 2'b01; icache_rdata = 32'h55;
    rst_n = 1'b0;
    settle();
    check("mr_cnt", 64'(outst_cnt), 64'd0);
    check("mr_req", 64'(icache_req), 64'd0);
    check("mr_iresp", 64'(imem_resp), 64'd0);
    check("mr_dresp", 64'(dmem_resp), 64'd0);
    tick();
    icache_resp = 2'b00; icache_rdata = '0;
    rst_n = 1'b1;
    imem_addr = 32'h100;
    settle();
    check("mr_first_iack", 64'(imem_req_ack), 64'd1);
    check("mr_first_addr", 64'(icache_addr), 64'h100);
    tick();
    imem_req = 1'b0;
    icache_resp = 2'b01; icache_rdata = 32'hC0;
    settle();
    check("mr_iresp_ok", 64'(imem_resp), 64'd1);
    check("mr_irdata", 64'(imem_rdata), 64'hC0);
    check("mr_dresp_none", 64'(dmem_resp), 64'd0);
    tick();
    icache_resp = 2'b00; icache_rdata = '0;
    settle();
    check("mr_end_cnt", 64'(outst_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
